prog_mem_arbiter: RTL and testbench
===================================

// Module: prog_mem_arbiter
// PURPOSE
//  Shares the single-port program memory between the instruction-fetch port (F, read-only)
//  and the program-loader port (L, read/write). Round-robin arbitration, one transaction in
//  flight, range/alignment check against the program window, translation to a word index,
//  and sequencing of a fixed-latency memory read.
// PARAMETERS
//  BASE     32'h0000_0240  first byte address of program window
//  LIMIT    32'h0000_123F  last byte address of program window (inclusive)
//  AW       10             memory word-index width ((LIMIT-BASE+1)/4 words)
//  MEM_LAT  1              cycles from mem_cs cycle to mem_rdata valid (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  f_req      in   1   fetch request; held until f_gnt
//  f_addr     in   32  fetch byte address; stable while f_req
//  f_gnt      out  1   fetch request accepted (combinational, IDLE only)
//  f_rvalid   out  1   fetch response, 1-cycle pulse
//  f_rdata    out  32  fetch read data, valid with f_rvalid
//  f_err      out  1   fetch access fault, valid with f_rvalid
//  l_req      in   1   loader request; held until l_gnt
//  l_we       in   1   loader write enable
//  l_addr     in   32  loader byte address
//  l_wdata    in   32  loader write data
//  l_gnt      out  1   loader request accepted
//  l_rvalid   out  1   loader response/write-complete, 1-cycle pulse
//  l_rdata    out  32  loader read data (0 for writes)
//  l_err      out  1   loader access fault
//  mem_cs     out  1   memory select, 1-cycle pulse
//  mem_we     out  1   memory write, only with mem_cs
//  mem_addr   out  AW  word index = (addr-BASE)>>2
//  mem_wdata  out  32  write data
//  mem_rdata  in   32  read data, valid MEM_LAT cycles after mem_cs cycle
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, last_grant=L (F wins first tie), all outputs and regs 0.
//  FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE; IDLE -> RESP on fault.
//  IDLE: winner = sole requester, or on tie the port not in last_grant. gnt to winner same
//   cycle; on that edge latch port, addr, we (F: 0), wdata; update last_grant.
//  Fault: addr<BASE | addr>LIMIT | addr[1:0]!=0 -> RESP with err=1, rdata=0; no mem_cs.
//  ACCESS: mem_cs=1 for exactly one cycle, mem_we=latched we, mem_addr[AW-1:0]=(addr-BASE)>>2.
//  WAIT: counter runs MEM_LAT cycles; in last WAIT cycle capture mem_rdata (reads only).
//  RESP: owner rvalid=1 one cycle with rdata/err; other port rvalid=0; then IDLE.
//  Timing (ok read, L=MEM_LAT): gnt cycle 0, mem_cs cycle 1, rdata capture cycle 1+L,
//   rvalid cycle 2+L. Fault: gnt cycle 0, rvalid+err cycle 1. Next gnt earliest cycle after RESP.
//  Requests arriving while busy are ignored until IDLE; held req then re-arbitrated.
//  Boundaries: BASE and LIMIT-3 in range; LIMIT-2..LIMIT faulted by alignment; LIMIT+1 faulted.
//  Subtraction 32-bit; only in-range addresses reach mem_addr, so no wrap.
//  rst_n low in any state: outputs 0 immediately; in-flight transaction dropped, no rvalid
//   after release; last_grant returns to L.
// TESTING
//  1 F read 0x240, MEM_LAT=1, mem word0=0x00000013 -> f_gnt c0, mem_cs c1 mem_addr=0,
//    f_rvalid c3 f_rdata=0x00000013 f_err=0.
//  2 L write 0x1000 data 0xDEADBEEF -> mem_cs&mem_we mem_addr=0x370; l_rvalid, l_err=0;
//    then F read 0x1000 -> f_rdata=0xDEADBEEF.
//  3 F read 0x23C, 0x1240, 0x123D, 0x242 -> f_rvalid c1 f_err=1 f_rdata=0; mem_cs never high.
//  4 F read 0x123C -> mem_addr=0x3FF, f_err=0.
//  5 f_req & l_req held high 8 txns -> grants F,L,F,L,...; no port granted twice in a row.
//  6 rst_n low during WAIT of F read -> busy/mem_cs/rvalid 0 at once; after release no
//    f_rvalid; next tie grants F.

Source files
------------

// File: rtl/prog_mem_arbiter_if.sv
// Bus bundle between the fetch port, the loader port and the program memory.
// The slave modport is the arbiter's view; master is the surrounding system.
interface prog_mem_arbiter_if #(
  parameter int AW = 10
);
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;

  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          l_err;

  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic          busy;

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata, f_err,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/prog_mem_arbiter.sv
// Round-robin arbiter sharing the single-port program memory between fetch and loader,
// with window/alignment checking and a fixed-latency read sequencer.
module prog_mem_arbiter #(
  parameter logic [31:0] BASE    = 32'h0000_0240,
  parameter logic [31:0] LIMIT   = 32'h0000_123F,
  parameter int          AW      = 10,
  parameter int          MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  prog_mem_arbiter_if.slave  bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state, state_d;
  logic          owner_l, owner_l_d;
  logic          last_l, last_l_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt, cnt_d;

  logic          f_win, l_win;
  logic [31:0]   sel_addr;
  logic [31:0]   offset;
  logic          fault;

  // Gating with rst_n keeps the grants low while reset is held, even with a request up.
  assign f_win    = rst_n & bus.f_req & (~bus.l_req | last_l);
  assign l_win    = rst_n & bus.l_req & ~f_win;
  assign sel_addr = l_win ? bus.l_addr : bus.f_addr;
  assign offset   = sel_addr - BASE;
  assign fault    = (sel_addr < BASE) || (sel_addr > LIMIT) || (sel_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner_l <= 1'b0;
      last_l  <= 1'b1;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_d;
      owner_l <= owner_l_d;
      last_l  <= last_l_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt     <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state;
    owner_l_d     = owner_l;
    last_l_d      = last_l;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    cnt_d         = cnt;

    bus.f_gnt     = 1'b0;
    bus.f_rvalid  = 1'b0;
    bus.f_rdata   = '0;
    bus.f_err     = 1'b0;
    bus.l_gnt     = 1'b0;
    bus.l_rvalid  = 1'b0;
    bus.l_rdata   = '0;
    bus.l_err     = 1'b0;
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = (state != IDLE);

    case (state)
      IDLE: begin
        if (f_win || l_win) begin
          bus.f_gnt = f_win;
          bus.l_gnt = l_win;
          owner_l_d = l_win;
          last_l_d  = l_win;
          we_d      = l_win & bus.l_we;
          wdata_d   = l_win ? bus.l_wdata : 32'h0;
          rdata_d   = '0;
          cnt_d     = '0;
          // Faulted accesses skip the memory entirely and answer on the next cycle.
          if (fault) begin
            err_d   = 1'b1;
            addr_d  = '0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            addr_d  = offset[AW+1:2];
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        bus.mem_cs    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        cnt_d         = '0;
        state_d       = WAIT;
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          if (!we_q) rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RESP: begin
        if (owner_l) begin
          bus.l_rvalid = 1'b1;
          bus.l_rdata  = rdata_q;
          bus.l_err    = err_q;
        end else begin
          bus.f_rvalid = 1'b1;
          bus.f_rdata  = rdata_q;
          bus.f_err    = err_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter with a one-cycle-latency memory model.
module tb_prog_mem_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  int          gnt_cyc, cs_cyc, rv_cyc, cs_count, other_rv;
  logic [9:0]  cs_addr;
  logic        cs_we;
  logic [31:0] cs_wdata, rv_data;
  logic        rv_err;

  logic [31:0] fault_addrs [4];
  logic [7:0]  seq;
  int          n_gnt, both_gnt, late_rv;

  prog_mem_arbiter_if #(.AW(10)) bus ();

  prog_mem_arbiter #(
    .BASE(32'h0000_0240), .LIMIT(32'h0000_123F), .AW(10), .MEM_LAT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read data appears the cycle after mem_cs
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Runs one transaction on a port, recording event cycles relative to the grant cycle
  task automatic applyStimulus(input bit port_l, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    gnt_cyc = -1; cs_cyc = -1; rv_cyc = -1; cs_count = 0; other_rv = 0;
    cs_addr = '0; cs_we = 1'b0; cs_wdata = '0; rv_data = '0; rv_err = 1'b0;
    if (port_l) begin
      bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata;
    end else begin
      bus.f_req = 1'b1; bus.f_addr = addr;
    end
    for (int c = 0; c < 40 && rv_cyc < 0; c++) begin
      #1;
      if (gnt_cyc < 0 && (port_l ? bus.l_gnt : bus.f_gnt)) gnt_cyc = c;
      if (bus.mem_cs) begin
        cs_count++;
        cs_cyc   = c - gnt_cyc;
        cs_addr  = bus.mem_addr;
        cs_we    = bus.mem_we;
        cs_wdata = bus.mem_wdata;
      end
      if (port_l ? bus.l_rvalid : bus.f_rvalid) begin
        rv_cyc  = c - gnt_cyc;
        rv_data = port_l ? bus.l_rdata : bus.f_rdata;
        rv_err  = port_l ? bus.l_err : bus.f_err;
      end
      if (port_l ? bus.f_rvalid : bus.l_rvalid) other_rv++;
      @(negedge clk);
      if (gnt_cyc >= 0) begin
        bus.f_req = 1'b0;
        bus.l_req = 1'b0;
      end
    end
    bus.f_req = 1'b0;
    bus.l_req = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int c = 0; c < 20 && bus.busy; c++) @(negedge clk);
    #1;
    checkOutput(tag, {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("rst_cs", {31'b0, bus.mem_cs}, 32'h0);
    checkOutput("rst_rvalid", {30'b0, bus.f_rvalid, bus.l_rvalid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
    fault_addrs[0] = 32'h0000_023C;
    fault_addrs[1] = 32'h0000_1240;
    fault_addrs[2] = 32'h0000_123D;
    fault_addrs[3] = 32'h0000_0242;
    @(negedge clk);
    doReset();
    #1;
    checkOutput("idle_gnt", {30'b0, bus.f_gnt, bus.l_gnt}, 32'h0);
    @(negedge clk);

    // Preload word 0 through the loader
    applyStimulus(1'b1, 1'b1, 32'h0000_0240, 32'h0000_0013);
    checkOutput("pre_cs_addr", {22'b0, cs_addr}, 32'h0);
    checkOutput("pre_err", {31'b0, rv_err}, 32'h0);
    @(negedge clk);

    // Test 1: fetch read of word 0
    applyStimulus(1'b0, 1'b0, 32'h0000_0240, 32'h0);
    checkOutput("t1_gnt", gnt_cyc, 32'd0);
    checkOutput("t1_cs_cyc", cs_cyc, 32'd1);
    checkOutput("t1_cs_addr", {22'b0, cs_addr}, 32'h0);
    checkOutput("t1_cs_we", {31'b0, cs_we}, 32'h0);
    checkOutput("t1_rv_cyc", rv_cyc, 32'd3);
    checkOutput("t1_rdata", rv_data, 32'h0000_0013);
    checkOutput("t1_err", {31'b0, rv_err}, 32'h0);
    checkOutput("t1_other", other_rv, 32'd0);
    @(negedge clk);

    // Test 2: loader write then fetch read-back
    applyStimulus(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    checkOutput("t2_cs_addr", {22'b0, cs_addr}, 32'h370);
    checkOutput("t2_cs_we", {31'b0, cs_we}, 32'h1);
    checkOutput("t2_wdata", cs_wdata, 32'hDEAD_BEEF);
    checkOutput("t2_rv_cyc", rv_cyc, 32'd3);
    checkOutput("t2_err", {31'b0, rv_err}, 32'h0);
    checkOutput("t2_rdata", rv_data, 32'h0);
    checkOutput("t2_other", other_rv, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0000_1000, 32'h0);
    checkOutput("t2_rdback", rv_data, 32'hDEAD_BEEF);
    @(negedge clk);

    // Test 3: out-of-window and misaligned fetches
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, fault_addrs[i], 32'h0);
      checkOutput($sformatf("t3_rv_cyc_%0d", i), rv_cyc, 32'd1);
      checkOutput($sformatf("t3_err_%0d", i), {31'b0, rv_err}, 32'h1);
      checkOutput($sformatf("t3_rdata_%0d", i), rv_data, 32'h0);
      checkOutput($sformatf("t3_cs_%0d", i), cs_count, 32'd0);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b1, 32'h0000_1240, 32'h1234_5678);
    checkOutput("t3_l_err", {31'b0, rv_err}, 32'h1);
    checkOutput("t3_l_cs", cs_count, 32'd0);
    @(negedge clk);

    // Test 4: last aligned word of the window
    applyStimulus(1'b0, 1'b0, 32'h0000_123C, 32'h0);
    checkOutput("t4_cs_addr", {22'b0, cs_addr}, 32'h3FF);
    checkOutput("t4_err", {31'b0, rv_err}, 32'h0);
    @(negedge clk);

    // Test 5: both ports requesting continuously after a fresh reset
    doReset();
    bus.f_req = 1'b1; bus.f_addr = 32'h0000_0240;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h0000_0244;
    n_gnt = 0; both_gnt = 0; seq = '0;
    for (int c = 0; c < 200 && n_gnt < 8; c++) begin
      #1;
      if (bus.f_gnt && bus.l_gnt) both_gnt++;
      if (bus.f_gnt) begin
        seq[n_gnt] = 1'b0; n_gnt++;
      end else if (bus.l_gnt) begin
        seq[n_gnt] = 1'b1; n_gnt++;
      end
      @(negedge clk);
    end
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    checkOutput("t5_count", n_gnt, 32'd8);
    checkOutput("t5_both", both_gnt, 32'd0);
    checkOutput("t5_seq", {24'b0, seq}, 32'h0000_00AA);
    waitIdle("t5_idle");

    // Test 6: reset asserted in the middle of a read
    bus.f_req = 1'b1; bus.f_addr = 32'h0000_0240;
    #1;
    checkOutput("t6_gnt", {31'b0, bus.f_gnt}, 32'h1);
    @(negedge clk);
    bus.f_req = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("t6_busy_pre", {31'b0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("t6_cs", {31'b0, bus.mem_cs}, 32'h0);
    checkOutput("t6_rvalid", {30'b0, bus.f_rvalid, bus.l_rvalid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    late_rv = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.f_rvalid) late_rv++;
      @(negedge clk);
    end
    checkOutput("t6_no_rv", late_rv, 32'd0);
    bus.f_req = 1'b1; bus.f_addr = 32'h0000_0240;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h0000_0244;
    #1;
    checkOutput("t6_tie", {30'b0, bus.f_gnt, bus.l_gnt}, 32'h2);
    @(negedge clk);
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    waitIdle("t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
